// File: rtl/jtframe_ps2_rx.sv
// PS/2 keyboard receiver: synchronise, deglitch, deframe, fold E0/F0 prefixes into key flags.
// Optional frame watchdog enabled with `define JTFRAME_PS2_TIMEOUT_EN.
module jtframe_ps2_rx #(
   parameter int FILTER_LEN = 8,
   parameter int TIMEOUT    = 96000
) (
   input  logic       clk_sys,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       key_valid,
   output logic [7:0] key_code,
   output logic       key_ext,
   output logic       key_rel,
   output logic       parity_err,
   output logic       frame_err
);

   localparam logic [3:0] FILT_LAST = 4'(FILTER_LEN - 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   // Parameter values outside the supported range leave this marker in the hierarchy
   if (FILTER_LEN < 1 || FILTER_LEN > 15 || TIMEOUT < 2) begin : g_bad_params
   end

   function automatic logic odd_parity_ok(input logic [7:0] byte_in, input logic par_in);
      return ^{byte_in, par_in};
   endfunction

   logic [1:0] clk_p0, data_p0;
   logic       clk_filt_p1, data_filt_p1, clk_filt_p2;
   logic [3:0] clk_cnt, data_cnt;
   logic       fall;

   state_t     state, state_nx;
   logic [7:0] shreg;
   logic [2:0] bitcnt;
   logic       par, ext_pend, rel_pend;
   logic       start, shift_en, par_en, deliver, perr, ferr, wd_expire;

   // Stage p0: two-flop synchronisers
   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         clk_p0  <= 2'b11;
         data_p0 <= 2'b11;
      end else begin
         clk_p0  <= {clk_p0[0], ps2_clk};
         data_p0 <= {data_p0[0], ps2_data};
      end
   end

   // Stage p1: a new level is accepted only after FILTER_LEN matching samples
   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         clk_filt_p1  <= 1'b1;
         clk_cnt      <= '0;
         data_filt_p1 <= 1'b1;
         data_cnt     <= '0;
      end else begin
         if (clk_p0[1] == clk_filt_p1) clk_cnt <= '0;
         else if (clk_cnt == FILT_LAST) begin
            clk_filt_p1 <= clk_p0[1];
            clk_cnt     <= '0;
         end else clk_cnt <= clk_cnt + 4'd1;
         if (data_p0[1] == data_filt_p1) data_cnt <= '0;
         else if (data_cnt == FILT_LAST) begin
            data_filt_p1 <= data_p0[1];
            data_cnt     <= '0;
         end else data_cnt <= data_cnt + 4'd1;
      end
   end

   // Stage p2: previous filtered clock for edge detection
   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) clk_filt_p2 <= 1'b1;
      else     clk_filt_p2 <= clk_filt_p1;
   end

   assign fall = clk_filt_p2 & ~clk_filt_p1;

`ifdef JTFRAME_PS2_TIMEOUT_EN
   localparam logic [16:0] WD_LAST = 17'(TIMEOUT - 1);
   logic [16:0] wd_cnt;

   // A fall in the expiry cycle keeps the frame alive
   assign wd_expire = (state != IDLE) && !fall && (wd_cnt == WD_LAST);

   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst)                                   wd_cnt <= '0;
      else if (state == IDLE || fall || wd_expire) wd_cnt <= '0;
      else                                       wd_cnt <= wd_cnt + 17'd1;
   end
`else
   assign wd_expire = 1'b0;
`endif

   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      start    = 1'b0;
      shift_en = 1'b0;
      par_en   = 1'b0;
      deliver  = 1'b0;
      perr     = 1'b0;
      ferr     = 1'b0;
      if (wd_expire) begin
         state_nx = IDLE;
         ferr     = 1'b1;
      end else if (fall) begin
         case (state)
            IDLE: if (!data_filt_p1) begin
               state_nx = DATA;
               start    = 1'b1;
            end
            DATA: begin
               shift_en = 1'b1;
               if (bitcnt == 3'd7) state_nx = PARITY;
            end
            PARITY: begin
               par_en   = 1'b1;
               state_nx = STOP;
            end
            STOP: begin
               state_nx = IDLE;
               if (!data_filt_p1)                 ferr    = 1'b1;
               else if (!odd_parity_ok(shreg, par)) perr    = 1'b1;
               else                               deliver = 1'b1;
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   // Stage p3: deframed byte becomes a key event or a pending prefix
   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         shreg      <= '0;
         bitcnt     <= '0;
         par        <= 1'b0;
         ext_pend   <= 1'b0;
         rel_pend   <= 1'b0;
         key_valid  <= 1'b0;
         key_code   <= '0;
         key_ext    <= 1'b0;
         key_rel    <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         key_valid  <= 1'b0;
         parity_err <= perr;
         frame_err  <= ferr;
         if (start) bitcnt <= '0;
         if (shift_en) begin
            shreg  <= {data_filt_p1, shreg[7:1]};
            bitcnt <= bitcnt + 3'd1;
         end
         if (par_en) par <= data_filt_p1;
         if (perr || ferr) begin
            ext_pend <= 1'b0;
            rel_pend <= 1'b0;
         end
         if (deliver) begin
            if (shreg == 8'hE0)      ext_pend <= 1'b1;
            else if (shreg == 8'hF0) rel_pend <= 1'b1;
            else begin
               key_valid <= 1'b1;
               key_code  <= shreg;
               key_ext   <= ext_pend;
               key_rel   <= rel_pend;
               ext_pend  <= 1'b0;
               rel_pend  <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_jtframe_ps2_rx.sv
// Randomised bench for jtframe_ps2_rx against a frame-level event model.
// Honours `define JTFRAME_PS2_TIMEOUT_EN for the watchdog scenario.
module tb_jtframe_ps2_rx;

   localparam int FL  = 8;
   localparam int TO  = 1000;
   localparam int H   = 25;            // PS/2 half period in clk_sys cycles
   localparam int LAT = 2 + FL + 1;    // raw stop-bit fall to strobe

   typedef struct {
      int     kind;   // 0 key, 1 parity error, 2 frame error
      int     code;
      int     ext;
      int     rel;
      longint cyc;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic       key_valid, key_ext, key_rel, parity_err, frame_err;
   logic [7:0] key_code;

   int     n_chk = 0;
   int     n_fail = 0;
   longint cyc = 0;
   longint t_stop = 0;
   longint t_fall = 0;
   ev_t    obs_q[$];
   ev_t    exp_q[$];
   bit     m_ext = 1'b0;
   bit     m_rel = 1'b0;

   jtframe_ps2_rx #(.FILTER_LEN(FL), .TIMEOUT(TO)) dut (
      .clk_sys   (clk),
      .rst       (rst),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .key_valid (key_valid),
      .key_code  (key_code),
      .key_ext   (key_ext),
      .key_rel   (key_rel),
      .parity_err(parity_err),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk_eq(input string tag, input longint got, input longint exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // Record every strobe cycle as an event
   always @(negedge clk) begin : mon
      ev_t ev;
      if (!rst && (key_valid || parity_err || frame_err)) begin
         chk_eq("strobe_excl", int'(key_valid) + int'(parity_err) + int'(frame_err), 1);
         ev.kind = key_valid ? 0 : (parity_err ? 1 : 2);
         ev.code = int'(key_code);
         ev.ext  = int'(key_ext);
         ev.rel  = int'(key_rel);
         ev.cyc  = cyc;
         obs_q.push_back(ev);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Reference: what one complete frame should produce at the key interface
   task automatic model_frame(input logic [7:0] b, input bit par_ok, input bit stop_ok);
      ev_t ev;
      ev.code = 0; ev.ext = 0; ev.rel = 0; ev.cyc = 0;
      if (!stop_ok) begin
         ev.kind = 2; exp_q.push_back(ev); m_ext = 0; m_rel = 0;
      end else if (!par_ok) begin
         ev.kind = 1; exp_q.push_back(ev); m_ext = 0; m_rel = 0;
      end else if (b == 8'hE0) m_ext = 1;
      else if (b == 8'hF0) m_rel = 1;
      else begin
         ev.kind = 0; ev.code = int'(b); ev.ext = int'(m_ext); ev.rel = int'(m_rel);
         exp_q.push_back(ev);
         m_ext = 0; m_rel = 0;
      end
   endtask

   task automatic send_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int first, input int last, input int glitch_bit);
      logic [10:0] f;
      f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
      for (int i = first; i <= last; i++) begin
         ps2_data = f[i];
         if (i == glitch_bit) begin
            tick(6); ps2_clk = 1'b0; tick(3); ps2_clk = 1'b1; tick(H - 9);
         end else tick(H);
         ps2_clk = 1'b0;
         t_fall = cyc;
         if (i == 10) t_stop = cyc;
         tick(H);
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
   endtask

   task automatic compare_events(input string tag);
      ev_t o, e;
      chk_eq({tag, "_nevents"}, obs_q.size(), exp_q.size());
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         chk_eq({tag, "_kind"}, o.kind, e.kind);
         chk_eq({tag, "_latency"}, o.cyc - t_stop, LAT);
         if (e.kind == 0) begin
            chk_eq({tag, "_code"}, o.code, e.code);
            chk_eq({tag, "_ext"}, o.ext, e.ext);
            chk_eq({tag, "_rel"}, o.rel, e.rel);
         end
      end
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic frame(input string tag, input logic [7:0] b, input bit bad_par,
                        input bit bad_stop, input int glitch_bit);
      model_frame(b, !bad_par, !bad_stop);
      send_bits(b, bad_par, bad_stop, 0, 10, glitch_bit);
      tick(30);
      compare_events(tag);
   endtask

   task automatic check_outputs_zero(input string tag);
      chk_eq({tag, "_key_valid"}, key_valid, 0);
      chk_eq({tag, "_key_code"}, key_code, 0);
      chk_eq({tag, "_key_ext"}, key_ext, 0);
      chk_eq({tag, "_key_rel"}, key_rel, 0);
      chk_eq({tag, "_parity_err"}, parity_err, 0);
      chk_eq({tag, "_frame_err"}, frame_err, 0);
   endtask

   initial begin
      ev_t ev;
      int  waited;
      logic [7:0] b;
      int  r;

      tick(3);
      check_outputs_zero("reset");
      rst = 1'b0;
      tick(20);

      frame("k1c", 8'h1C, 0, 0, -1);
      frame("e0", 8'hE0, 0, 0, -1);
      frame("f0", 8'hF0, 0, 0, -1);
      frame("k75_ext_rel", 8'h75, 0, 0, -1);
      frame("k75_plain", 8'h75, 0, 0, -1);
      frame("f0_before_perr", 8'hF0, 0, 0, -1);
      frame("k1c_bad_par", 8'h1C, 1, 0, -1);
      frame("k1c_after_perr", 8'h1C, 0, 0, -1);
      frame("k29_bad_stop", 8'h29, 0, 1, -1);
      frame("k29_after_ferr", 8'h29, 0, 0, -1);
      frame("both_bad", 8'h29, 1, 1, -1);
      frame("e1_plain", 8'hE1, 0, 0, -1);
      frame("glitch", 8'h3A, 0, 0, 4);

      // Asynchronous reset in the middle of a frame with a release prefix pending
      frame("f0_before_rst", 8'hF0, 0, 0, -1);
      send_bits(8'h5A, 0, 0, 0, 5, -1);
      ps2_data = 1'b1;
      tick(10);
      #3 rst = 1'b1;
      #1 check_outputs_zero("midframe_rst");
      obs_q.delete(); exp_q.delete();
      m_ext = 0; m_rel = 0;
      tick(3);
      rst = 1'b0;
      tick(20);
      frame("k5a_after_rst", 8'h5A, 0, 0, -1);

`ifdef JTFRAME_PS2_TIMEOUT_EN
      send_bits(8'h1C, 0, 0, 0, 3, -1);
      waited = 0;
      while (obs_q.size() == 0 && waited < 1500) begin
         tick(1);
         waited++;
      end
      if (obs_q.size() == 0) chk_eq("timeout_seen", 0, 1);
      else begin
         ev = obs_q.pop_front();
         chk_eq("timeout_kind", ev.kind, 2);
         chk_eq("timeout_latency", ev.cyc - t_fall, LAT + TO);
      end
      tick(5);
      chk_eq("timeout_single", obs_q.size(), 0);
      obs_q.delete();
      m_ext = 0; m_rel = 0;
      frame("k1c_after_timeout", 8'h1C, 0, 0, -1);
`else
      send_bits(8'h1C, 0, 0, 0, 3, -1);
      tick(TO + 200);
      chk_eq("no_timeout", obs_q.size(), 0);
      model_frame(8'h1C, 1, 1);
      send_bits(8'h1C, 0, 0, 4, 10, -1);
      tick(30);
      compare_events("truncated_resume");
`endif

      for (int i = 0; i < 40; i++) begin
         r = int'($urandom_range(0, 9));
         if (r <= 1)      b = 8'hE0;
         else if (r == 2) b = 8'hF0;
         else if (r == 3) b = 8'hE1;
         else             b = 8'($urandom_range(0, 255));
         frame("rand", b, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, -1);
         tick(int'($urandom_range(0, 20)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/jtframe_ps2_rx.md
Name: jtframe_ps2_rx

Overview:
- PS/2 keyboard receiver on the core side of the keyboard link; the IO controller drives that link as transmitter.
- Synchronises and deglitches the ps2 clock/data lines, deframes 11-bit frames and checks parity and stop bit.
- Folds E0 (extended) and F0 (break) prefixes into flags attached to the next scancode.
- Feeds the keyboard-to-joystick mapper with a single-cycle strobe per key event.

Parameters:
- FILTER_LEN, 8: consecutive identical synchronised samples needed before a line level is accepted (1..15).
- TIMEOUT, 96000: clk_sys cycles without a filtered falling edge before an open frame is aborted (2 ms at 48 MHz); counter width 17 bits.

Ports:
- clk_sys  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- ps2_clk  in  1  PS/2 clock line, asynchronous to clk_sys, idle high
- ps2_data  in  1  PS/2 data line, asynchronous, idle high
- key_valid  out  1  one-cycle strobe: key_code/key_ext/key_rel valid
- key_code  out  8  scancode, excluding prefixes
- key_ext  out  1  code was preceded by E0
- key_rel  out  1  code was preceded by F0 (key release)
- parity_err  out  1  one-cycle strobe: frame dropped on odd-parity failure
- frame_err  out  1  one-cycle strobe: frame dropped on bad stop bit or timeout

Behaviour:
- Reset: every output is 0; the FSM is in IDLE; the prefix latches ext_pend and rel_pend are 0; the filtered line levels are 1; all counters are 0. Reset is asynchronous, including mid-frame.
- Input path:
  - 2-FF synchroniser on each line.
  - Per-line filter: the level is accepted after FILTER_LEN equal consecutive samples.
  - fall = filtered clk was 1 last cycle and is 0 now.
  - Data is sampled as the filtered data level in the fall cycle.
- FSM, advanced only on fall unless stated otherwise:
  - IDLE: data=0 -> DATA with bitcnt=0. data=1 -> stay in IDLE (spurious edge, no error).
  - DATA: shift data into shreg[7] and shift right (LSB first); bitcnt++. After the 8th bit -> PARITY.
  - PARITY: store data as par. -> STOP.
  - STOP, data=1 and ^{shreg,par}=1 -> deliver byte, then IDLE.
  - STOP, data=1 and parity fails -> parity_err=1 for one cycle; clear ext_pend and rel_pend; IDLE.
  - STOP, data=0 -> frame_err=1 for one cycle; clear both pends; IDLE. Stop-bit failure takes priority over parity failure.
- Delivery, registered in the cycle after the stop-bit fall:
  - byte 0xE0 -> ext_pend=1, no strobe.
  - byte 0xF0 -> rel_pend=1, no strobe.
  - any other byte -> key_code=byte, key_ext=ext_pend, key_rel=rel_pend, key_valid=1 for one cycle; then clear both pends.
  - key_code, key_ext and key_rel hold their values until the next delivery.
- Latency: key_valid rises exactly 1 clk_sys cycle after the fall cycle of the stop bit. From the raw pin edge this is 2 + FILTER_LEN + 1 cycles.
- Prefix sequences:
  - E0 F0 xx gives ext=1, rel=1.
  - Repeated E0 is idempotent.
  - E1 (Pause) is not special: it is delivered as a plain code.
- Strobes are never asserted simultaneously. At most one of key_valid, parity_err and frame_err is high in any cycle.
- Host-to-device transmission is not supported; both lines are input-only.

Optional Feature:
- Macro: JTFRAME_PS2_TIMEOUT_EN.
- Defined:
  - A watchdog counts clk_sys cycles while the FSM is not in IDLE and resets to 0 on every fall.
  - When it reaches TIMEOUT: frame_err=1 for one cycle, both pends cleared, FSM to IDLE.
  - If fall occurs in the same cycle as expiry, fall wins and there is no error.
- Undefined: no watchdog and no counter logic. A truncated frame stays open until further falls complete it.

Test Plan:
- Frame 0x1C: start 0, data LSB-first 0,0,1,1,1,0,0,0, parity 0, stop 1, PS/2 clock at 12 kHz -> key_valid for one cycle, key_code=0x1C, ext=0, rel=0, no error strobes.
- Frames E0, F0, 0x75 back-to-back -> exactly one key_valid, with key_code=0x75, key_ext=1, key_rel=1. A following 0x75 frame gives ext=0, rel=0.
- Frame 0x1C sent with parity=1 -> parity_err for one cycle, no key_valid. A preceding F0 is discarded: the next 0x1C gives rel=0.
- Frame 0x29 with stop bit=0 -> frame_err for one cycle, no key_valid. A following good 0x29 decodes normally.
- With JTFRAME_PS2_TIMEOUT_EN, TIMEOUT=1000: send 4 bits then stop the clock -> frame_err exactly 1000 cycles after the last fall. A following 0x1C frame decodes correctly. Without the macro, no frame_err is raised.
- Assert rst during bit 5 of a frame -> all outputs 0 and FSM in IDLE. A full 0x5A frame after reset decodes with ext=0, rel=0. A 3-cycle low glitch on ps2_clk (FILTER_LEN=8) produces no fall.
